// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - N-digit multiplexed seven-segment scan driver with double-buffered load
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   value_in     4*NUM_DIGITS nibbles, nibble k = digit k (captured when load=1)
//   dot_in       NUM_DIGITS decimal points, bit k = digit k (captured with value_in)
//   load         1-cycle request to capture value_in/dot_in
//   hex_en       1: A-F shown as hex glyphs, 0: A-F shown blank (live)
//   blank_lz     1: suppress leading zeros on digits above digit 0 (live)
//   seg_out      segments {g,f,e,d,c,b,a}, active-high
//   dp_out       decimal point of the driven digit
//   dig_sel      one-hot enable of the driven digit
//   load_ack     1-cycle pulse when a new value is committed to the display
//   frame_start  1-cycle pulse coinciding with the digit-0 output
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 2,
    parameter int REFRESH_DIV = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   value_in,
    input  logic [NUM_DIGITS-1:0]     dot_in,
    input  logic                      load,
    input  logic                      hex_en,
    input  logic                      blank_lz,
    output logic [6:0]                seg_out,
    output logic                      dp_out,
    output logic [NUM_DIGITS-1:0]     dig_sel,
    output logic                      load_ack,
    output logic                      frame_start
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CW-1:0]           ref_cnt;
    logic [IW-1:0]           scan_idx;
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dot;
    logic [4*NUM_DIGITS-1:0] pending_val;
    logic [NUM_DIGITS-1:0]   pending_dot;
    logic                    pending_valid;

    logic                    last_cnt;
    logic                    last_idx;
    logic                    boundary;
    logic [3:0]              cur_nib;
    logic                    cur_dot;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   onehot;
    logic [NUM_DIGITS-1:0]   zero_above;
    logic                    all_zero;

    function automatic logic [6:0] glyph(input logic [3:0] nib, input logic hex);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'b0111111;
            4'h1: g = 7'b0000110;
            4'h2: g = 7'b1011011;
            4'h3: g = 7'b1001111;
            4'h4: g = 7'b1100110;
            4'h5: g = 7'b1101101;
            4'h6: g = 7'b1111101;
            4'h7: g = 7'b0000111;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1101111;
            4'hA: g = 7'b1110111;
            4'hB: g = 7'b1111100;
            4'hC: g = 7'b0111001;
            4'hD: g = 7'b1011110;
            4'hE: g = 7'b1111001;
            default: g = 7'b1110001;
        endcase
        if (!hex && nib > 4'h9) begin
            g = 7'b0000000;
        end
        return g;
    endfunction

    assign last_cnt = (ref_cnt == CW'(REFRESH_DIV - 1));
    assign last_idx = (scan_idx == IW'(NUM_DIGITS - 1));
    assign boundary = last_cnt && last_idx;

    // Select the digit currently being scanned and work out leading-zero
    // blanking: zero_above[k] is set when nibbles k..N-1 are all zero.
    always_comb begin
        cur_nib    = 4'h0;
        cur_dot    = 1'b0;
        cur_blank  = 1'b0;
        onehot     = '0;
        zero_above = '0;
        all_zero   = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            all_zero      = all_zero && (shadow_val[k*4 +: 4] == 4'h0);
            zero_above[k] = all_zero;
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (scan_idx == IW'(k)) begin
                onehot[k] = 1'b1;
                cur_nib   = shadow_val[k*4 +: 4];
                cur_dot   = shadow_dot[k];
                cur_blank = (k > 0) && blank_lz && zero_above[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ref_cnt       <= '0;
            scan_idx      <= '0;
            shadow_val    <= '0;
            shadow_dot    <= '0;
            pending_val   <= '0;
            pending_dot   <= '0;
            pending_valid <= 1'b0;
            seg_out       <= 7'b0;
            dp_out        <= 1'b0;
            dig_sel       <= '0;
            load_ack      <= 1'b0;
            frame_start   <= 1'b0;
        end else begin
            if (last_cnt) begin
                ref_cnt  <= '0;
                scan_idx <= last_idx ? '0 : scan_idx + IW'(1);
            end else begin
                ref_cnt <= ref_cnt + CW'(1);
            end

            // Outputs follow the pre-edge scan index, so the frame pulse is
            // raised on the first cycle of digit 0 to line up with its output.
            seg_out     <= cur_blank ? 7'b0 : glyph(cur_nib, hex_en);
            dp_out      <= cur_dot;
            dig_sel     <= onehot;
            frame_start <= (ref_cnt == '0) && (scan_idx == '0);

            load_ack <= 1'b0;
            if (boundary) begin
                // A load arriving on the boundary itself is newer than any
                // pending value, so it bypasses the pending buffer.
                if (load) begin
                    shadow_val    <= value_in;
                    shadow_dot    <= dot_in;
                    pending_valid <= 1'b0;
                    load_ack      <= 1'b1;
                end else if (pending_valid) begin
                    shadow_val    <= pending_val;
                    shadow_dot    <= pending_dot;
                    pending_valid <= 1'b0;
                    load_ack      <= 1'b1;
                end
            end else if (load) begin
                pending_val   <= value_in;
                pending_dot   <= dot_in;
                pending_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver (2 digits, 4-cycle refresh)
module tb_seg7_scan_driver;

    localparam logic [6:0] G0 = 7'b0111111;
    localparam logic [6:0] G2 = 7'b1011011;
    localparam logic [6:0] G3 = 7'b1001111;
    localparam logic [6:0] G4 = 7'b1100110;
    localparam logic [6:0] G5 = 7'b1101101;
    localparam logic [6:0] G7 = 7'b0000111;
    localparam logic [6:0] GA = 7'b1110111;
    localparam logic [6:0] GF = 7'b1110001;
    localparam logic [6:0] GB = 7'b0000000;

    typedef struct packed {
        logic [6:0] s0;
        logic [6:0] s1;
        logic       d0;
        logic       d1;
    } frame_t;

    logic       clk;
    logic       reset;
    logic [7:0] value_in;
    logic [1:0] dot_in;
    logic       load;
    logic       hex_en;
    logic       blank_lz;
    logic [6:0] seg_out;
    logic       dp_out;
    logic [1:0] dig_sel;
    logic       load_ack;
    logic       frame_start;

    int     vectors;
    int     errors;
    int     ack_cnt;
    int     ack_base;
    frame_t exp_q[$];

    seg7_scan_driver #(.NUM_DIGITS(2), .REFRESH_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .value_in   (value_in),
        .dot_in     (dot_in),
        .load       (load),
        .hex_en     (hex_en),
        .blank_lz   (blank_lz),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .dig_sel    (dig_sel),
        .load_ack   (load_ack),
        .frame_start(frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // load_ack is read at the edge, i.e. the value held during the cycle just ended.
    always @(posedge clk) begin
        if (reset) ack_cnt <= 0;
        else if (load_ack === 1'b1) ack_cnt <= ack_cnt + 1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] v, input logic [1:0] d);
        value_in = v;
        dot_in   = d;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    // Waits (bounded) for the digit-0 cycle of a frame, then checks both digits
    // against the oldest expected frame. Returns on the first digit-1 cycle.
    task automatic check_frame(input string tag);
        frame_t e;
        int     n;
        e = exp_q.pop_front();
        n = 0;
        while (frame_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_frame_start"}, {31'd0, frame_start}, 32'd1);
        chk({tag, "_dig0_sel"},    {30'd0, dig_sel}, 32'd1);
        chk({tag, "_dig0_seg"},    {25'd0, seg_out}, {25'd0, e.s0});
        chk({tag, "_dig0_dp"},     {31'd0, dp_out},  {31'd0, e.d0});
        repeat (4) tick();
        chk({tag, "_dig1_sel"},    {30'd0, dig_sel}, 32'd2);
        chk({tag, "_dig1_seg"},    {25'd0, seg_out}, {25'd0, e.s1});
        chk({tag, "_dig1_dp"},     {31'd0, dp_out},  {31'd0, e.d1});
    endtask

    initial begin
        vectors  = 0;
        errors   = 0;
        reset    = 1'b1;
        value_in = 8'h00;
        dot_in   = 2'b00;
        load     = 1'b0;
        hex_en   = 1'b0;
        blank_lz = 1'b0;

        // 1. reset state, first frame timing
        repeat (3) tick();
        chk("rst_seg",   {25'd0, seg_out},     32'd0);
        chk("rst_dp",    {31'd0, dp_out},      32'd0);
        chk("rst_sel",   {30'd0, dig_sel},     32'd0);
        chk("rst_ack",   {31'd0, load_ack},    32'd0);
        chk("rst_fs",    {31'd0, frame_start}, 32'd0);
        reset = 1'b0;
        tick();
        chk("first_sel", {30'd0, dig_sel},     32'd1);
        chk("first_seg", {25'd0, seg_out},     {25'd0, G0});
        chk("first_fs",  {31'd0, frame_start}, 32'd1);
        repeat (4) tick();
        chk("hold_sel",  {30'd0, dig_sel},     32'd2);
        chk("hold_fs",   {31'd0, frame_start}, 32'd0);
        repeat (4) tick();
        chk("period_fs",  {31'd0, frame_start}, 32'd1);
        chk("period_sel", {30'd0, dig_sel},     32'd1);
        repeat (4) tick();

        // 2. mid-frame load of 23 in decimal mode
        ack_base = ack_cnt;
        do_load(8'h23, 2'b00);
        chk("no_tear_seg", {25'd0, seg_out}, {25'd0, G0});
        exp_q.push_back('{s0: G3, s1: G2, d0: 1'b0, d1: 1'b0});
        check_frame("load23");
        chk("load23_ack", ack_cnt - ack_base, 32'd1);

        // 3. hex glyphs, then hex_en dropped live
        hex_en = 1'b1;
        do_load(8'hAF, 2'b01);
        exp_q.push_back('{s0: GF, s1: GA, d0: 1'b1, d1: 1'b0});
        check_frame("hexAF");
        hex_en = 1'b0;
        tick();
        chk("hex_off_live", {25'd0, seg_out}, {25'd0, GB});
        exp_q.push_back('{s0: GB, s1: GB, d0: 1'b1, d1: 1'b0});
        check_frame("hexoff");

        // 4. leading-zero blanking, dp kept on a blanked digit
        blank_lz = 1'b1;
        do_load(8'h05, 2'b10);
        exp_q.push_back('{s0: G5, s1: GB, d0: 1'b0, d1: 1'b1});
        check_frame("lz05");
        do_load(8'h00, 2'b00);
        exp_q.push_back('{s0: G0, s1: GB, d0: 1'b0, d1: 1'b0});
        check_frame("lz00");
        blank_lz = 1'b0;

        // 5. latest pending load wins; boundary load bypasses pending
        ack_base = ack_cnt;
        do_load(8'h11, 2'b00);
        do_load(8'h42, 2'b00);
        exp_q.push_back('{s0: G2, s1: G4, d0: 1'b0, d1: 1'b0});
        check_frame("load42");
        chk("load42_ack", ack_cnt - ack_base, 32'd1);
        ack_base = ack_cnt;
        repeat (2) tick();
        do_load(8'h77, 2'b00);
        exp_q.push_back('{s0: G7, s1: G7, d0: 1'b0, d1: 1'b0});
        check_frame("bnd77");
        chk("bnd77_ack", ack_cnt - ack_base, 32'd1);

        // 6. reset mid-frame discards a pending load
        do_load(8'h99, 2'b11);
        reset = 1'b1;
        tick();
        chk("midrst_seg", {25'd0, seg_out}, 32'd0);
        chk("midrst_sel", {30'd0, dig_sel}, 32'd0);
        chk("midrst_dp",  {31'd0, dp_out},  32'd0);
        tick();
        reset = 1'b0;
        exp_q.push_back('{s0: G0, s1: G0, d0: 1'b0, d1: 1'b0});
        check_frame("after_rst");
        exp_q.push_back('{s0: G0, s1: G0, d0: 1'b0, d1: 1'b0});
        check_frame("after_rst2");
        chk("after_rst_ack", ack_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
